x_wave_seq: RTL and testbench

X_WAVE_SEQ -- requirements
Module: x_wave_seq

---
 rtl/x_wave_seq.sv | 148 ++++++++++++++
 tb/tb_x_wave_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_wave_seq.sv
// Waveform sequencer: loads 2-bit samples into an external 2048x2 RAM, then plays them
// back cyclically at a programmable rate with a two-cycle read-to-strobe latency.
module x_wave_seq #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_load_start,
    input  logic             i_load_valid,
    input  logic             i_load_last,
    input  logic [1:0]       i_load_data,
    output logic             o_load_ready,
    input  logic             i_play,
    input  logic [DIV_W-1:0] i_div,
    output logic [10:0]      o_mem_addr,
    output logic             o_mem_we,
    output logic [1:0]       o_mem_wdata,
    input  logic [1:0]       i_mem_rdata,
    output logic [1:0]       o_sample,
    output logic             o_sample_valid,
    output logic [11:0]      o_len,
    output logic             o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY} state_t;

    state_t           state_q, state_d;
    logic [10:0]      wptr_q, wptr_d;
    logic [10:0]      rptr_q, rptr_d;
    logic [DIV_W-1:0] divcnt_q, divcnt_d;
    logic [11:0]      len_q, len_d;
    logic             rd_pend_q, rd_pend_d;
    logic [1:0]       sample_q, sample_d;
    logic             sample_vld_q, sample_vld_d;

    logic beat;
    logic load_done;
    logic play_go;
    logic tick;
    logic rptr_last;

    assign beat      = (state_q == ST_LOAD) && i_load_valid;
    assign load_done = beat && (i_load_last || (wptr_q == 11'd2047));
    assign play_go   = (state_q == ST_IDLE) && !i_load_start && i_play && (len_q != 12'd0);
    // A shrinking divider makes the counter overshoot; treat that as an immediate tick.
    assign tick      = (state_q == ST_PLAY) && i_play && (divcnt_q >= i_div);
    assign rptr_last = ({1'b0, rptr_q} == (len_q - 12'd1));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load_start) begin
                    state_d = ST_LOAD;
                end else if (play_go) begin
                    state_d = ST_PLAY;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Stay until the last issued read has produced its strobe.
                if (!i_play && !rd_pend_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_load_ready   = (state_q == ST_LOAD);
        o_mem_we       = beat;
        o_mem_wdata    = (state_q == ST_LOAD) ? i_load_data : 2'd0;
        o_mem_addr     = 11'd0;
        if (state_q == ST_LOAD) begin
            o_mem_addr = wptr_q;
        end else if (state_q == ST_PLAY) begin
            o_mem_addr = rptr_q;
        end
        o_sample       = sample_q;
        o_sample_valid = sample_vld_q;
        o_len          = len_q;
        o_busy         = (state_q != ST_IDLE);
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        divcnt_d     = divcnt_q;
        len_d        = len_q;
        rd_pend_d    = tick;
        sample_vld_d = rd_pend_q;
        sample_d     = rd_pend_q ? i_mem_rdata : sample_q;

        if ((state_q == ST_IDLE) && i_load_start) begin
            wptr_d = 11'd0;
        end
        if (play_go) begin
            rptr_d   = 11'd0;
            divcnt_d = '0;
        end
        if (beat) begin
            wptr_d = wptr_q + 11'd1;
        end
        if (load_done) begin
            len_d = {1'b0, wptr_q} + 12'd1;
        end
        if (tick) begin
            rptr_d   = rptr_last ? 11'd0 : (rptr_q + 11'd1);
            divcnt_d = '0;
        end else if ((state_q == ST_PLAY) && i_play) begin
            divcnt_d = divcnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wptr_q       <= 11'd0;
            rptr_q       <= 11'd0;
            divcnt_q     <= '0;
            len_q        <= 12'd0;
            rd_pend_q    <= 1'b0;
            sample_q     <= 2'd0;
            sample_vld_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            divcnt_q     <= divcnt_d;
            len_q        <= len_d;
            rd_pend_q    <= rd_pend_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
        end
    end

endmodule

// File: tb/tb_x_wave_seq.sv
// Bench for x_wave_seq: RAM model, cycle-level behavioural reference with strobe schedule,
// directed scenarios plus randomized load/play rounds.
module tb_x_wave_seq;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_load_start = 1'b0;
    logic        i_load_valid = 1'b0;
    logic        i_load_last = 1'b0;
    logic [1:0]  i_load_data = 2'd0;
    logic        o_load_ready;
    logic        i_play = 1'b0;
    logic [7:0]  i_div = 8'd0;
    logic [10:0] o_mem_addr;
    logic        o_mem_we;
    logic [1:0]  o_mem_wdata;
    logic [1:0]  i_mem_rdata = 2'd0;
    logic [1:0]  o_sample;
    logic        o_sample_valid;
    logic [11:0] o_len;
    logic        o_busy;

    x_wave_seq #(.DIV_W(8)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_load_start(i_load_start), .i_load_valid(i_load_valid),
        .i_load_last(i_load_last), .i_load_data(i_load_data),
        .o_load_ready(o_load_ready), .i_play(i_play), .i_div(i_div),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_sample(o_sample), .o_sample_valid(o_sample_valid),
        .o_len(o_len), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    logic [1:0] ram [0:2047];
    always @(posedge i_clk) begin
        if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
        else          i_mem_rdata <= ram[o_mem_addr];
    end

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle, 1=load, 2=play; strobes scheduled by absolute cycle.
    int         cyc = 0;
    int         mode = 0;
    int         n_ld = 0;
    int         len_m = 0;
    int         idx = 0;
    int         cnt = 0;
    logic [1:0] wave [0:2047];
    int         sq_t[$];
    logic [1:0] sq_v[$];
    logic [1:0] held = 2'd0;
    logic [1:0] got[$];
    bit         m_tick;
    bit         m_strobe;

    always @(negedge i_clk) begin
        if (!i_nrst) begin
            chk("rst_busy", int'(o_busy), 0);
            chk("rst_valid", int'(o_sample_valid), 0);
            chk("rst_sample", int'(o_sample), 0);
            chk("rst_len", int'(o_len), 0);
            chk("rst_ready", int'(o_load_ready), 0);
            chk("rst_we", int'(o_mem_we), 0);
            chk("rst_addr", int'(o_mem_addr), 0);
            mode = 0; n_ld = 0; len_m = 0; idx = 0; cnt = 0; held = 2'd0;
            sq_t.delete(); sq_v.delete();
        end else begin
            m_tick   = (mode == 2) && i_play && (cnt >= int'(i_div));
            m_strobe = (sq_t.size() > 0) && (sq_t[0] == cyc);
            if (m_strobe) begin
                held = sq_v[0];
                void'(sq_t.pop_front());
                void'(sq_v.pop_front());
            end
            chk("sample_valid", int'(o_sample_valid), int'(m_strobe));
            chk("sample", int'(o_sample), int'(held));
            if (o_sample_valid) got.push_back(o_sample);
            chk("busy", int'(o_busy), int'(mode != 0));
            chk("load_ready", int'(o_load_ready), int'(mode == 1));
            chk("len", int'(o_len), len_m);
            chk("mem_we", int'(o_mem_we), int'((mode == 1) && i_load_valid));
            if ((mode == 1) && i_load_valid) begin
                chk("wr_addr", int'(o_mem_addr), n_ld);
                chk("wr_data", int'(o_mem_wdata), int'(i_load_data));
            end
            if (m_tick) chk("rd_addr", int'(o_mem_addr), idx);

            case (mode)
                0: begin
                    if (i_load_start) begin
                        mode = 1; n_ld = 0;
                    end else if (i_play && len_m != 0) begin
                        mode = 2; idx = 0; cnt = 0;
                    end
                end
                1: begin
                    if (i_load_valid) begin
                        wave[n_ld] = i_load_data;
                        n_ld++;
                        if (i_load_last || n_ld == 2048) begin
                            len_m = n_ld; mode = 0;
                        end
                    end
                end
                default: begin
                    if (i_play) begin
                        if (m_tick) begin
                            sq_t.push_back(cyc + 2);
                            sq_v.push_back(wave[idx]);
                            idx = (idx + 1) % len_m;
                            cnt = 0;
                        end else begin
                            cnt++;
                        end
                    end else if (sq_t.size() == 0 || sq_t[$] <= cyc) begin
                        mode = 0;
                    end
                end
            endcase
        end
        cyc++;
    end

    logic [1:0] ld_data [0:2047];

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic beats(input int n, input bit use_last, input int gap_pct);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            i_load_valid = ($urandom_range(99) >= gap_pct);
            i_load_data  = ld_data[sent];
            i_load_last  = use_last && (sent == n - 1);
            step(1);
            if (i_load_valid) sent++;
            guard++;
        end
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
        chk("load_timeout", sent, n);
    endtask

    task automatic load(input int n, input bit use_last, input int gap_pct);
        i_load_start = 1'b1;
        step(1);
        i_load_start = 1'b0;
        beats(n, use_last, gap_pct);
        step(1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_busy && k < 50) begin
            step(1);
            k++;
        end
        chk("drain_timeout", int'(o_busy), 0);
    endtask

    task automatic play(input int cycles, input int div, input bit vary, input bit chk_inflight);
        int n0;
        i_div  = 8'(div);
        i_play = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (vary) i_div = 8'($urandom_range(0, 3));
            step(1);
        end
        i_play = 1'b0;
        n0 = got.size();
        wait_idle();
        if (chk_inflight) chk("inflight_strobes", got.size() - n0, 2);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) ld_data[i] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("por_busy", int'(o_busy), 0);
        chk("por_addr", int'(o_mem_addr), 0);
        step(2);
        i_nrst = 1'b1;
        step(1);

        // Play request with nothing stored, then load-start and play together.
        got.delete();
        i_play = 1'b1;
        step(5);
        chk("empty_play_busy", int'(o_busy), 0);
        chk("empty_play_strobes", got.size(), 0);
        i_load_start = 1'b1;
        step(1);
        i_load_start = 1'b0;
        i_play = 1'b0;
        chk("start_wins_ready", int'(o_load_ready), 1);
        ld_data[0] = 2'd1; ld_data[1] = 2'd2; ld_data[2] = 2'd3; ld_data[3] = 2'd0;
        beats(4, 1'b1, 0);
        step(1);
        chk("len4", int'(o_len), 4);
        got.delete();
        play(12, 0, 1'b0, 1'b1);
        if (got.size() >= 6) begin
            chk("seq0", int'(got[0]), 1);
            chk("seq1", int'(got[1]), 2);
            chk("seq2", int'(got[2]), 3);
            chk("seq3", int'(got[3]), 0);
            chk("seq4", int'(got[4]), 1);
            chk("seq5", int'(got[5]), 2);
        end else begin
            chk("seq_count", got.size(), 6);
        end

        // Gapped 3-beat load, divider 2.
        fill_random(3);
        load(3, 1'b1, 40);
        chk("len3", int'(o_len), 3);
        got.delete();
        play(20, 2, 1'b0, 1'b0);
        chk("div2_count", got.size(), 6);
        if (got.size() >= 4) chk("period3", int'(got[3]), int'(ld_data[0]));

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 40);
            fill_random(n);
            load(n, 1'b1, $urandom_range(0, 50));
            chk("rand_len", int'(o_len), n);
            play($urandom_range(3, 60), $urandom_range(0, 4), r[0], 1'b0);
            step($urandom_range(0, 3));
        end

        // Full-depth load with no last marker, playback wrap.
        fill_random(2048);
        load(2048, 1'b0, 0);
        chk("len2048", int'(o_len), 2048);
        chk("idle_after_full", int'(o_busy), 0);
        got.delete();
        play(2060, 0, 1'b0, 1'b1);
        if (got.size() > 2049) begin
            chk("wrap_first", int'(got[2048]), int'(ld_data[0]));
            chk("wrap_second", int'(got[2049]), int'(ld_data[1]));
        end else begin
            chk("wrap_count", got.size(), 2050);
        end

        // Reset in the middle of a load.
        fill_random(10);
        i_load_start = 1'b1;
        step(1);
        i_load_start = 1'b0;
        i_load_valid = 1'b1;
        i_load_data  = 2'd3;
        step(3);
        #2;
        i_nrst = 1'b0;
        #1;
        chk("abort_ld_ready", int'(o_load_ready), 0);
        chk("abort_ld_we", int'(o_mem_we), 0);
        chk("abort_ld_len", int'(o_len), 0);
        chk("abort_ld_busy", int'(o_busy), 0);
        i_load_valid = 1'b0;
        step(2);
        i_nrst = 1'b1;
        i_play = 1'b1;
        step(5);
        chk("post_abort_busy", int'(o_busy), 0);
        i_play = 1'b0;

        // Reset in the middle of playback.
        fill_random(4);
        load(4, 1'b1, 0);
        i_div  = 8'd0;
        i_play = 1'b1;
        step(7);
        #2;
        i_nrst = 1'b0;
        #1;
        chk("abort_pl_valid", int'(o_sample_valid), 0);
        chk("abort_pl_sample", int'(o_sample), 0);
        chk("abort_pl_len", int'(o_len), 0);
        chk("abort_pl_busy", int'(o_busy), 0);
        chk("abort_pl_addr", int'(o_mem_addr), 0);
        step(2);
        i_nrst = 1'b1;
        step(5);
        chk("post_abort_play_busy", int'(o_busy), 0);
        i_play = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
